// File: rtl/hazard_control_unit_pkg.sv
// hazard_control_unit_pkg: shared definitions for the hazard controller and the pipeline top.
// Contents: branch encodings as the ID stage presents them, controller FSM states, and a
// branch-decision helper.
package hazard_control_unit_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_JUMP = 2'b11
    } branch_e;

    typedef enum logic {
        RUN        = 1'b0,
        LOAD_STALL = 1'b1
    } hz_state_e;

    // Conditional branches read rs/rt in ID, so only they can raise an operand hazard.
    function automatic logic br_cond(logic [1:0] br);
        return br == BR_BEQ || br == BR_BNE;
    endfunction

    function automatic logic br_taken(logic [1:0] br, logic eq);
        return (br == BR_BEQ && eq) || (br == BR_BNE && !eq) || br == BR_JUMP;
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if: pipeline-to-hazard-unit signal bundle.
// Inputs to the unit: ID operands, EX/MEM destination info, branch info, dmem_busy, cnt_clr.
// Outputs from the unit: pc_write, IF_ID_write, mux_hz_unit, pipe_en, flush, counters.
// master = pipeline side, slave = hazard_control_unit.
interface hazard_control_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] IF_ID_rs;
    logic [REG_AW-1:0] IF_ID_rt;
    logic              IF_ID_uses_rt;
    logic [REG_AW-1:0] ID_EX_dst;
    logic              ID_EX_reg_write;
    logic              ID_EX_mem_read;
    logic [REG_AW-1:0] EX_MEM_dst;
    logic              EX_MEM_mem_read;
    logic [1:0]        branch;
    logic              equal;
    logic              dmem_busy;
    logic              cnt_clr;
    logic              pc_write;
    logic              IF_ID_write;
    logic              mux_hz_unit;
    logic              pipe_en;
    logic              flush;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        output IF_ID_rs, IF_ID_rt, IF_ID_uses_rt, ID_EX_dst, ID_EX_reg_write, ID_EX_mem_read,
               EX_MEM_dst, EX_MEM_mem_read, branch, equal, dmem_busy, cnt_clr,
        input  pc_write, IF_ID_write, mux_hz_unit, pipe_en, flush, stall_cycles, flush_count
    );

    modport slave (
        input  IF_ID_rs, IF_ID_rt, IF_ID_uses_rt, ID_EX_dst, ID_EX_reg_write, ID_EX_mem_read,
               EX_MEM_dst, EX_MEM_mem_read, branch, equal, dmem_busy, cnt_clr,
        output pc_write, IF_ID_write, mux_hz_unit, pipe_en, flush, stall_cycles, flush_count
    );

endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
// Ports: clk, rst_n (async, active-low), inc_i (count this cycle), clr_i (zero on next edge,
// wins over inc_i), cnt_o (current count).
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use / branch-operand stall, memory freeze and flush control for
// the 5-stage MIPS pipeline, plus saturating stall and flush counters.
// Ports: clk, rst_n (async, active-low), hz_if (slave side of hazard_control_unit_if).
module hazard_control_unit #(
    parameter int REG_AW       = 5,
    parameter int LOAD_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    hazard_control_unit_if.slave hz_if
);
    import hazard_control_unit_pkg::*;

    localparam int REM_W = $clog2(LOAD_LATENCY + 1) < 1 ? 1 : $clog2(LOAD_LATENCY + 1);

    hz_state_e        state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             pc_w, ifid_w, mux_w, pipe_w, flush_w;
    logic             load_use, br_haz;

    // Register 0 is hardwired, so a match on it is never a real dependency.
    function automatic logic hit(logic [REG_AW-1:0] dst, logic [REG_AW-1:0] src);
        return dst != '0 && dst == src;
    endfunction

    assign load_use = hz_if.ID_EX_mem_read &&
                      (hit(hz_if.ID_EX_dst, hz_if.IF_ID_rs) ||
                       (hz_if.IF_ID_uses_rt && hit(hz_if.ID_EX_dst, hz_if.IF_ID_rt)));

    assign br_haz = br_cond(hz_if.branch) &&
                    ((hz_if.ID_EX_reg_write &&
                      (hit(hz_if.ID_EX_dst, hz_if.IF_ID_rs) || hit(hz_if.ID_EX_dst, hz_if.IF_ID_rt))) ||
                     (hz_if.EX_MEM_mem_read &&
                      (hit(hz_if.EX_MEM_dst, hz_if.IF_ID_rs) || hit(hz_if.EX_MEM_dst, hz_if.IF_ID_rt))));

    // Outputs are forced low while rst_n is low so the reset values appear asynchronously.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        pc_w    = 1'b1;
        ifid_w  = 1'b1;
        mux_w   = 1'b1;
        pipe_w  = 1'b1;
        flush_w = 1'b0;
        if (!rst_n) begin
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            mux_w  = 1'b0;
            pipe_w = 1'b0;
        end else if (hz_if.dmem_busy) begin
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            pipe_w = 1'b0;
        end else if (state_q == LOAD_STALL) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            mux_w   = 1'b0;
            rem_d   = rem_q - REM_W'(1);
            state_d = rem_q == REM_W'(1) ? RUN : LOAD_STALL;
        end else if (load_use) begin
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            mux_w  = 1'b0;
            if (LOAD_LATENCY > 1) begin
                state_d = LOAD_STALL;
                rem_d   = REM_W'(LOAD_LATENCY - 1);
            end
        end else if (br_haz) begin
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            mux_w  = 1'b0;
        end else begin
            flush_w = br_taken(hz_if.branch, hz_if.equal);
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= RUN;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end

    assign hz_if.pc_write    = pc_w;
    assign hz_if.IF_ID_write = ifid_w;
    assign hz_if.mux_hz_unit = mux_w;
    assign hz_if.pipe_en     = pipe_w;
    assign hz_if.flush       = flush_w;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (!pc_w),
        .clr_i (hz_if.cnt_clr),
        .cnt_o (hz_if.stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (flush_w),
        .clr_i (hz_if.cnt_clr),
        .cnt_o (hz_if.flush_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: scoreboard bench for two controllers (LOAD_LATENCY=1/CNT_W=16 and
// LOAD_LATENCY=3/CNT_W=4) sharing clk and rst_n.
module tb_hazard_control_unit;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic [4:0] ex_dst;
        logic       ex_rw;
        logic       ex_mr;
        logic [4:0] mem_dst;
        logic       mem_mr;
        logic [1:0] branch;
        logic       equal;
        logic       busy;
        logic       clr;
    } stim_t;

    typedef struct {
        int          which;
        string       name;
        logic [4:0]  ctl;
        bit          chk_cnt;
        logic [15:0] st;
        logic [15:0] fl;
    } exp_t;

    // ctl = {pc_write, IF_ID_write, mux_hz_unit, pipe_en, flush}
    localparam logic [4:0] C_RUN = 5'b11110;
    localparam logic [4:0] C_TKN = 5'b11111;
    localparam logic [4:0] C_BUB = 5'b00010;
    localparam logic [4:0] C_FRZ = 5'b00100;
    localparam logic [4:0] C_RST = 5'b00000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    stim_t       s0, s1;
    exp_t        q[$];
    exp_t        e;
    logic [4:0]  act_ctl;
    logic [15:0] act_st, act_fl;
    int          checks = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    hazard_control_unit_if #(.REG_AW(5), .CNT_W(16)) ia ();
    hazard_control_unit_if #(.REG_AW(5), .CNT_W(4))  ib ();

    assign {ia.IF_ID_rs, ia.IF_ID_rt, ia.IF_ID_uses_rt, ia.ID_EX_dst, ia.ID_EX_reg_write,
            ia.ID_EX_mem_read, ia.EX_MEM_dst, ia.EX_MEM_mem_read, ia.branch, ia.equal,
            ia.dmem_busy, ia.cnt_clr} = s0;
    assign {ib.IF_ID_rs, ib.IF_ID_rt, ib.IF_ID_uses_rt, ib.ID_EX_dst, ib.ID_EX_reg_write,
            ib.ID_EX_mem_read, ib.EX_MEM_dst, ib.EX_MEM_mem_read, ib.branch, ib.equal,
            ib.dmem_busy, ib.cnt_clr} = s1;

    hazard_control_unit #(.REG_AW(5), .LOAD_LATENCY(1), .CNT_W(16)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .hz_if (ia)
    );

    hazard_control_unit #(.REG_AW(5), .LOAD_LATENCY(3), .CNT_W(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .hz_if (ib)
    );

    function automatic stim_t mk(int rs, int rt, int u, int ed, int erw, int emr,
                                 int md, int mmr, int br, int eq, int bsy, int clr);
        return {5'(rs), 5'(rt), 1'(u), 5'(ed), 1'(erw), 1'(emr),
                5'(md), 1'(mmr), 2'(br), 1'(eq), 1'(bsy), 1'(clr)};
    endfunction

    // Queue the expected response for the current cycle, then advance to just after the next edge.
    task automatic step(int which, string name, logic [4:0] ctl, bit chk, int st, int fl);
        exp_t x;
        x.which   = which;
        x.name    = name;
        x.ctl     = ctl;
        x.chk_cnt = chk;
        x.st      = 16'(st);
        x.fl      = 16'(fl);
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            act_ctl = e.which == 1 ?
                      {ib.pc_write, ib.IF_ID_write, ib.mux_hz_unit, ib.pipe_en, ib.flush} :
                      {ia.pc_write, ia.IF_ID_write, ia.mux_hz_unit, ia.pipe_en, ia.flush};
            act_st = e.which == 1 ? 16'(ib.stall_cycles) : ia.stall_cycles;
            act_fl = e.which == 1 ? 16'(ib.flush_count) : ia.flush_count;
            checks++;
            if (act_ctl === e.ctl && (!e.chk_cnt || (act_st === e.st && act_fl === e.fl)))
                passed++;
            else
                $display("FAIL %s: got ctl=%b stall=%0d flush=%0d, want ctl=%b stall=%0d flush=%0d%s",
                         e.name, act_ctl, act_st, act_fl, e.ctl, e.st, e.fl,
                         e.chk_cnt ? "" : " (counters not checked)");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        s0 = '0;
        s1 = '0;
        @(posedge clk);
        #1;
        step(0, "rst_a", C_RST, 1, 0, 0);
        step(1, "rst_b", C_RST, 1, 0, 0);
        rst_n = 1'b1;
        step(0, "idle_a", C_RUN, 1, 0, 0);
        // lw $3 in EX, add $4,$3,$5 in ID, single bubble
        s0 = mk(3, 5, 1, 3, 1, 1, 0, 0, 0, 0, 0, 0);
        step(0, "lu1_bubble", C_BUB, 1, 0, 0);
        s0 = mk(3, 5, 1, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        step(0, "lu1_run", C_RUN, 1, 1, 0);
        s0 = '0;
        // three bubbles with a two-cycle freeze after the first
        s1 = mk(3, 5, 1, 3, 1, 1, 0, 0, 0, 0, 0, 0);
        step(1, "lu3_bub1", C_BUB, 1, 0, 0);
        s1 = mk(3, 5, 1, 0, 0, 0, 3, 1, 0, 0, 1, 0);
        step(1, "lu3_frz1", C_FRZ, 1, 1, 0);
        step(1, "lu3_frz2", C_FRZ, 1, 2, 0);
        s1.busy = 1'b0;
        step(1, "lu3_bub2", C_BUB, 1, 3, 0);
        step(1, "lu3_bub3", C_BUB, 1, 4, 0);
        step(1, "lu3_run", C_RUN, 1, 5, 0);
        s1 = '0;
        // beq $2,$7 with add $7 in EX
        s0 = mk(2, 7, 1, 7, 1, 0, 0, 0, 1, 1, 0, 0);
        step(0, "br_bubble", C_BUB, 1, 1, 0);
        s0 = mk(2, 7, 1, 0, 0, 0, 7, 0, 1, 1, 0, 0);
        step(0, "br_taken", C_TKN, 1, 2, 0);
        s0 = mk(2, 9, 1, 0, 0, 0, 9, 1, 2, 0, 0, 0);
        step(0, "br_memload", C_BUB, 1, 2, 1);
        s0 = mk(2, 9, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0);
        step(0, "bne_eq", C_RUN, 1, 3, 1);
        s0 = mk(2, 9, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        step(0, "bne_ne", C_TKN, 1, 3, 1);
        s0 = mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        step(0, "jump_ne", C_TKN, 1, 3, 2);
        s0.equal = 1'b1;
        step(0, "jump_eq", C_TKN, 1, 3, 3);
        s0 = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, "none_after", C_RUN, 1, 3, 4);
        // $0 and unused rt never stall
        s0 = mk(0, 0, 1, 0, 1, 1, 0, 1, 1, 0, 0, 0);
        step(0, "zero_reg", C_RUN, 1, 3, 4);
        s0 = mk(1, 6, 0, 6, 1, 1, 0, 0, 0, 0, 0, 0);
        step(0, "unused_rt", C_RUN, 1, 3, 4);
        // load-use coincident with a taken beq, then the EX_MEM load bubble, then the flush
        s0 = mk(2, 8, 1, 2, 1, 1, 0, 0, 1, 1, 0, 0);
        step(0, "lu_vs_br", C_BUB, 1, 3, 4);
        s0 = mk(2, 8, 1, 0, 0, 0, 2, 1, 1, 1, 0, 0);
        step(0, "br_after_lu", C_BUB, 1, 4, 4);
        s0 = mk(2, 8, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        step(0, "br_resolved", C_TKN, 1, 5, 4);
        // freeze masks a jump
        s0 = mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0);
        step(0, "frz_jump", C_FRZ, 1, 5, 5);
        s0.busy = 1'b0;
        step(0, "jump_after_frz", C_TKN, 1, 6, 5);
        // clear wins over a coincident increment
        s0 = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, "clr_frz", C_FRZ, 1, 6, 6);
        s0 = '0;
        step(0, "cleared_a", C_RUN, 1, 0, 0);
        // reset asserted mid-LOAD_STALL
        s1 = mk(3, 5, 1, 3, 1, 1, 0, 0, 0, 0, 0, 0);
        step(1, "lu3_again", C_BUB, 1, 5, 0);
        s1 = mk(3, 5, 1, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        step(1, "ls_bubble", C_BUB, 1, 6, 0);
        rst_n = 1'b0;
        step(1, "rst_async", C_RST, 1, 0, 0);
        rst_n = 1'b1;
        step(1, "run_after_rst", C_RUN, 1, 0, 0);
        // 20 stall cycles saturate a 4-bit counter
        s1 = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) step(1, "sat_frz", C_FRZ, 0, 0, 0);
        s1 = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, "sat15", C_RUN, 1, 15, 0);
        s1 = '0;
        step(1, "sat_clr", C_RUN, 1, 0, 0);
        @(negedge clk);
        if (ib.stall_cycles !== 4'd0)
            $display("FAIL final_clr: got stall=%0d, want stall=0", ib.stall_cycles);
        if (checks < 12)
            $display("FAIL check_count: got %0d checks, want at least 12", checks);
        if (passed != checks)
            $display("FAIL summary: got %0d passed, want %0d", passed, checks);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Parametrised hazard controller for the 5-stage pipelined MIPS core. It sits beside the IF/ID register and drives the PC write enable, the IF/ID write enable, the ID/EX bubble mux and the IF/ID flush. It also drives a global pipeline enable that freezes the pipeline while data memory is busy. It adds four things:

- multi-cycle load-use stalls;
- branch-operand stalls for branches resolved in ID;
- memory-wait freeze;
- saturating performance counters.

## Interface
Parameters:
- REG_AW, 5, register address width
- LOAD_LATENCY, 1, bubbles inserted for a load-use dependency (≥1)
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- IF_ID_rs, IF_ID_rt  in  REG_AW  source registers of the instruction in ID
- IF_ID_uses_rt  in  1  ID instruction reads rt
- ID_EX_dst  in  REG_AW  destination register of the instruction in EX
- ID_EX_reg_write, ID_EX_mem_read  in  1  EX instruction writes a register / is a load
- EX_MEM_dst  in  REG_AW  destination register of the instruction in MEM
- EX_MEM_mem_read  in  1  MEM instruction is a load
- branch  in  2  00 none, 01 beq, 10 bne, 11 jump
- equal  in  1  ID comparator result
- dmem_busy  in  1  data memory has not completed its access
- cnt_clr  in  1  synchronous clear of both counters
- pc_write, IF_ID_write  out  1  1 = update
- mux_hz_unit  out  1  0 = select zero controls into ID/EX (bubble)
- pipe_en  out  1  0 = hold ID/EX, EX/MEM and MEM/WB
- flush  out  1  1 = zero IF/ID on the next edge
- stall_cycles, flush_count  out  CNT_W  performance counters

## Operation
Matching on register 0 never counts as a dependency.

**FSM states:** RUN, LOAD_STALL (holds remaining-bubble counter rem).

**Per-cycle priority:**
1. **Freeze.** Condition: dmem_busy=1.
   - pc_write=0, IF_ID_write=0, pipe_en=0, mux_hz_unit=1, flush=0.
   - State and rem hold.
2. **LOAD_STALL.** Emit a bubble: pc_write=0, IF_ID_write=0, mux_hz_unit=0, pipe_en=1, flush=0.
   - rem decrements.
   - When rem goes from 1 to 0, the next state is RUN.
3. **Load-use.** Condition in RUN: ID_EX_mem_read and ID_EX_dst matches IF_ID_rs, or matches IF_ID_rt with IF_ID_uses_rt=1.
   - Emit a bubble this cycle.
   - If LOAD_LATENCY>1, go to LOAD_STALL with rem=LOAD_LATENCY-1.
4. **Branch operand.** Condition: branch is 01 or 10, and either:
   - ID_EX_reg_write with ID_EX_dst matching rs or rt, or
   - EX_MEM_mem_read with EX_MEM_dst matching rs or rt.
   - Emit one bubble; stay in RUN.
5. **Otherwise.**
   - pc_write=1, IF_ID_write=1, mux_hz_unit=1, pipe_en=1.
   - flush=1 iff (branch=01 and equal) or (branch=10 and !equal) or branch=11; else 0.

**Flush rules:**
- flush is fully combinational with a default of 0, so no latch is inferred.
- flush is never asserted in a stall or freeze cycle.

**Counters:**
- stall_cycles increments on every cycle with pc_write=0 (reset excluded).
- flush_count increments on every cycle with flush=1.
- Both saturate at all-ones.
- cnt_clr=1 zeroes both on the next edge and wins over increment.

## Timing
- Control outputs are combinational from state plus inputs, valid in the same cycle. State, rem and counters update on the rising clk edge.
- **Load-use:** exactly LOAD_LATENCY consecutive bubble cycles, excluding freeze cycles, which extend the sequence without consuming rem.
- **Branch operand stall:** exactly 1 bubble per hazard occurrence. A following ID_EX-to-EX_MEM load dependency can add one more bubble via rule 4.
- **While rst_n=0:**
  - state=RUN, rem=0, counters=0.
  - pc_write=0, IF_ID_write=0, pipe_en=0, mux_hz_unit=0, flush=0.
- **Reset deasserted mid-LOAD_STALL:** the stall is abandoned and operation resumes in RUN.
- **Simultaneous events:** dmem_busy masks a coincident load-use or branch; the hazard is re-evaluated once busy drops. A load-use hazard coincident with a taken branch yields a bubble and no flush; the flush occurs when the branch is re-evaluated.

## Structure
- **Shared package/header:** branch encodings (BR_NONE, BR_BEQ, BR_BNE, BR_JUMP) and the FSM state encoding. These are reused by the controller and the pipeline top.
- **Sub-module:** sat_counter (CNT_W, inc, clr), instantiated twice.
- rem width is $clog2(LOAD_LATENCY+1), with a minimum of 1.

## Test plan
- **Load-use, LOAD_LATENCY=1.** Setup: lw $3 in EX, add $4,$3,$5 in ID. Required:
  - exactly 1 cycle with pc_write=0, mux_hz_unit=0;
  - then RUN;
  - stall_cycles=1.
- **Load-use, LOAD_LATENCY=3.** Same stimulus as the first scenario. Required:
  - 3 consecutive bubbles;
  - with dmem_busy pulsed for 2 cycles during the 2nd bubble, a total of 5 cycles with pc_write=0 and still 3 bubbles.
- **Branch operand.** Setup: beq $2,$7 in ID, add $7 in EX (ID_EX_reg_write=1). Required:
  - 1 bubble, flush=0;
  - then, with equal=1 the next cycle, flush=1 and flush_count=1.
- **No stall on $0 or unused rt.** Setup: ID_EX_dst=0 with a load, and a match on rt with IF_ID_uses_rt=0. Required: pc_write=1 throughout.
- **Jump and bne.** Stimulus and required flush:
  - branch=11 gives flush=1 regardless of equal;
  - bne with equal=1 gives flush=0;
  - branch=00 after a taken branch gives flush=0 (no latch).
- **Reset and saturation.**
  - Assert rst_n=0 mid-LOAD_STALL: outputs take their reset values asynchronously, and RUN follows release.
  - With CNT_W=4: 20 stall cycles leave stall_cycles=15; cnt_clr then gives 0.
